// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, decrypt-stage FSM states and the InvShiftRows
// source-index helper.
package aes_pkg;
    localparam int AES_NBYTES = 16;
    typedef logic [127:0] state_t;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;
    // Output byte k = r+4c is read from column (c - r) mod 4 of the same row.
    function automatic logic [3:0] inv_shift_src(input logic [3:0] k);
        logic [1:0] c;
        c = k[3:2] - k[1:0];
        return {c, k[1:0]};
    endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box, byte 0x00 entry is the MSB
// of the table.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    assign y = INV_SBOX[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_subbytes_8b.sv
// aes_inv_subbytes_8b: byte-serial AES InvShiftRows + InvSubBytes, one byte
// per cycle through a single inverse S-box, optional post-S-box pipe register.
module aes_inv_subbytes_8b
    import aes_pkg::*;
#(
    parameter int PIPE   = 0,
    parameter int NBYTES = 16
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    if (NBYTES != AES_NBYTES) begin : g_bad_nbytes
        $fatal(1, "aes_inv_subbytes_8b: NBYTES must be 16");
    end
    if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
        $fatal(1, "aes_inv_subbytes_8b: PIPE must be 0 or 1");
    end

    fsm_t       st, nst;
    logic [3:0] cnt, pk;
    state_t     cap, res;
    byte_t      sb_in, sb_out, pd;
    logic       pv;

    // Byte k lives at bits [127-8k -: 8], i.e. offset 8*(15-k) = {~k, 3'b0}.
    assign sb_in = cap[{~inv_shift_src(cnt), 3'b000} +: 8];

    aes_inv_sbox u_sbox (
        .a(sb_in),
        .y(sb_out)
    );

    always_comb begin
        nst = st;
        case (st)
            IDLE:    nst = in_valid ? RUN : IDLE;
            RUN:     nst = (cnt == 4'd15) ? ((PIPE != 0) ? DRAIN : DONE) : RUN;
            DRAIN:   nst = DONE;
            DONE:    nst = out_ready ? IDLE : DONE;
            default: nst = IDLE;
        endcase
        if (flush) nst = IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st  <= IDLE;
            cnt <= '0;
            cap <= '0;
            res <= '0;
            pv  <= 1'b0;
            pk  <= '0;
            pd  <= '0;
        end else begin
            st <= nst;
            if (flush) begin
                cnt <= '0;
                pv  <= 1'b0;
            end else begin
                pv <= (PIPE != 0) && (st == RUN);
                if (st == IDLE && in_valid) begin
                    cap <= in_state;
                    cnt <= '0;
                end
                if (st == RUN) begin
                    cnt <= cnt + 4'd1;
                    pk  <= cnt;
                    pd  <= sb_out;
                    if (PIPE == 0) res[{~cnt, 3'b000} +: 8] <= sb_out;
                end
                if (pv) res[{~pk, 3'b000} +: 8] <= pd;
            end
        end
    end

    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign busy      = (st != IDLE);
    assign out_state = res;
endmodule

// File: tb/tb_aes_inv_subbytes_8b.sv
// tb_aes_inv_subbytes_8b: directed and round-trip checks of the byte-serial
// inverse substitution stage, PIPE=0 (dut0) and PIPE=1 (dut1).
module tb_aes_inv_subbytes_8b;
    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic         HRESETn;
    logic [1:0]   in_valid, flush, out_ready;
    logic [127:0] in_state [2];
    wire  [1:0]   in_ready, out_valid, busy;
    wire  [127:0] out_state [2];
    int checks = 0;
    int failures = 0;

    aes_inv_subbytes_8b #(.PIPE(0), .NBYTES(16)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
        .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .busy(busy[0])
    );
    aes_inv_subbytes_8b #(.PIPE(1), .NBYTES(16)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
        .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .busy(busy[1])
    );

    localparam logic [2047:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fsb(input logic [7:0] x);
        return FWD[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] x);
        for (int j = 0; j < 256; j++)
            if (fsb(8'(j)) == x) return 8'(j);
        return 8'h00;
    endfunction

    function automatic logic [127:0] fwd_round(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            int r, c, src;
            r = k % 4;
            c = k / 4;
            src = r + 4 * ((c + r) % 4);
            o[8*(15-k) +: 8] = fsb(s[8*(15-src) +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            int r, c, src;
            r = k % 4;
            c = k / 4;
            src = r + 4 * ((c - r + 4) % 4);
            o[8*(15-k) +: 8] = isb(s[8*(15-src) +: 8]);
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic send(input int sel, input logic [127:0] d);
        int n;
        in_state[sel] = d;
        in_valid[sel] = 1'b1;
        n = 0;
        while (!in_ready[sel] && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("accept_timeout", 128'(in_ready[sel]), 128'd1);
        step();
        in_valid[sel] = 1'b0;
    endtask

    task automatic wait_out(input int sel, output int n);
        n = 0;
        while (!out_valid[sel] && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic release_out(input int sel);
        out_ready[sel] = 1'b1;
        step();
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        int n;
        logic ov;
        logic [127:0] x, got, d;
        HRESETn = 1'b0;
        in_valid = '0;
        flush = '0;
        out_ready = '0;
        in_state[0] = '0;
        in_state[1] = '0;
        step();
        step();
        HRESETn = 1'b1;
        step();
        chk("rst_in_ready", 128'(in_ready), 128'd3);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_state0", out_state[0], 128'd0);
        chk("rst_out_state1", out_state[1], 128'd0);

        send(0, {16{8'h63}});
        chk("run_in_ready", 128'(in_ready[0]), 128'd0);
        chk("run_busy", 128'(busy[0]), 128'd1);
        wait_out(0, n);
        chk("lat_pipe0", 128'(n), 128'd16);
        chk("all63", out_state[0], 128'd0);
        release_out(0);
        chk("done_to_idle", 128'(busy[0]), 128'd0);

        d = 128'h000102030405060708090a0b0c0d0e0f;
        send(0, d);
        wait_out(0, n);
        chk("lat_seq", 128'(n), 128'd16);
        chk("seq_hand", out_state[0], 128'h52f3a338_3009d79e_bf366afb_8140a5d5);
        chk("seq_model", out_state[0], inv_model(d));
        release_out(0);

        send(1, {16{8'h16}});
        wait_out(1, n);
        chk("lat_pipe1", 128'(n), 128'd17);
        chk("all16", out_state[1], {16{8'hff}});
        in_state[1] = {16{8'h7c}};
        in_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_state", out_state[1], {16{8'hff}});
            chk("hold_valid", 128'(out_valid[1]), 128'd1);
            chk("hold_no_accept", 128'(in_ready[1]), 128'd0);
        end
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;
        chk("same_cycle_not_accepted", 128'(busy[1]), 128'd0);
        chk("idle_after_done", 128'(in_ready[1]), 128'd1);
        step();
        in_valid[1] = 1'b0;
        chk("accept_next_cycle", 128'(busy[1]), 128'd1);
        wait_out(1, n);
        chk("lat_7c", 128'(n), 128'd17);
        chk("all7c", out_state[1], {16{8'h01}});
        release_out(1);

        send(0, 128'h0123456789abcdeffedcba9876543210);
        repeat (7) step();
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("flush_idle", 128'(busy[0]), 128'd0);
        chk("flush_in_ready", 128'(in_ready[0]), 128'd1);
        ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ov |= out_valid[0];
            step();
        end
        chk("flush_no_valid", 128'(ov), 128'd0);
        d = 128'hdeadbeef00112233445566778899aabb;
        send(0, d);
        wait_out(0, n);
        chk("post_flush_lat", 128'(n), 128'd16);
        chk("post_flush_data", out_state[0], inv_model(d));
        release_out(0);

        send(0, 128'hcafef00d0badc0de1234567890abcdef);
        send(1, 128'h55aa55aa33cc33cc0ff00ff0a5a5a5a5);
        repeat (5) step();
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_out_state0", out_state[0], 128'd0);
        chk("arst_out_state1", out_state[1], 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        d = 128'h3243f6a8885a308d313198a2e0370734;
        send(1, d);
        wait_out(1, n);
        chk("post_rst_data", out_state[1], inv_model(d));
        release_out(1);

        for (int sel = 0; sel < 2; sel++) begin
            for (int t = 0; t < 500; t++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                send(sel, fwd_round(x));
                in_state[sel] = {$urandom, $urandom, $urandom, $urandom};
                got = 'x;
                n = 0;
                while (n < 200) begin
                    out_ready[sel] = 1'($urandom % 2);
                    if (out_valid[sel] && out_ready[sel]) begin
                        got = out_state[sel];
                        step();
                        break;
                    end
                    step();
                    n++;
                end
                out_ready[sel] = 1'b0;
                chk("roundtrip", got, x);
                chk("no_dup", 128'(out_valid[sel]), 128'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_inv_subbytes_8b.md
Name: aes_inv_subbytes_8b

Overview:
- Byte-serial AES InvShiftRows + InvSubBytes unit for the 8-bit-datapath decryption path.
- It is the decrypt counterpart of the forward substitution stage.
- Accepts a 128-bit state over a valid/ready handshake and pushes one byte per cycle through a single inverse S-box.
- Presents the transformed 128-bit state on a valid/ready output. It sits between the AddRoundKey/InvMixColumns stages of the decrypt round controller.

Parameters:
- PIPE, 0, 1 inserts a register after the inverse S-box (adds 1 cycle latency); 0 = combinational S-box into the result register.
- NBYTES, 16, bytes per state; fixed at 16, present only for elaboration checks (anything else is a $fatal).

Ports:
- HCLK  input  1  clock; all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- in_valid  input  1  input state valid.
- in_ready  output  1  unit can accept a state (high only in IDLE).
- in_state  input  128  state; byte k = bits [127-8k -: 8], k = r+4c (FIPS-197 column-major).
- flush  input  1  synchronous abort; returns to IDLE next cycle.
- out_valid  output  1  result valid (DONE state).
- out_ready  input  1  downstream accepts result.
- out_state  output  128  result, same byte ordering as in_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values (async, HRESETn low): state=IDLE, in_ready=1 once reset is released, out_valid=0, busy=0, out_state=0, byte counter=0, capture register=0, pipe register and pipe-valid=0.
- FSM IDLE -> RUN -> (DRAIN if PIPE=1) -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_state, cnt<=0, go RUN. out_state holds its previous value.
- RUN: each cycle process output byte k=cnt (r=k%4, c=k/4).
  - Source index src = r + 4*((c - r) mod 4), arithmetic mod 4 on 2-bit c.
  - result[k] <= InvSbox(cap[src]) when PIPE=0.
  - When PIPE=1, the pipe register captures (k, InvSbox(cap[src])) and writes result[k] one cycle later.
  - cnt increments by 1. At cnt==15: PIPE=0 -> DONE; PIPE=1 -> DRAIN. cnt wraps to 0.
- DRAIN (PIPE=1 only): the final pipe write lands, then go DONE.
- DONE: out_valid=1, out_state = result. out_state and out_valid are stable until out_ready. On out_ready, go IDLE.
- Latency: handshake accepted at edge T; out_valid high after edge T+16 (PIPE=0) or T+17 (PIPE=1).
- Throughput: one state per 18 (PIPE=0) or 19 (PIPE=1) cycles with out_ready tied high.
- No in_valid acceptance while busy. Back-to-back inputs are held off by in_ready=0. Simultaneous out_ready in DONE and in_valid: the input is not accepted that cycle; it is accepted the following cycle in IDLE.
- flush has priority over all transitions in any state.
  - Next state is IDLE; cnt=0; pipe-valid=0; out_valid=0.
  - result register is not cleared.
- Async reset mid-RUN aborts immediately; all registers take reset values.
- in_state changes after capture have no effect.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t (logic [127:0]) and byte_t (logic [7:0]).
  - Enum for the FSM states.
  - Function inv_shift_src(k) returning the 4-bit source index.
  - Constant AES_NBYTES=16.
- Sub-module aes_inv_sbox: combinational 8-bit in/out inverse S-box lookup table, the inverse of the forward S-box, instantiated once.

Test Plan:
1. Reset then all bytes 0x63, PIPE=0 -> out_valid at T+16, out_state = 128'h0; in_ready low during RUN.
2. in_state byte k = k (0x00..0x0f) -> out byte0 = 0x52 (InvSbox(00)), byte1 = InvSbox(0x0d) = 0xf3, byte4 = InvSbox(0x04) = 0x30, byte5 = InvSbox(0x01) = 0x09. Check all 16 bytes against the software model.
3. All bytes 0x16, then all bytes 0x7c, with PIPE=1 -> all 0xff at T+17, then all 0x01. out_ready held low 5 cycles: out_state stable, no second accept.
4. flush asserted at cnt=7 -> IDLE next cycle, out_valid never rises. A new state is accepted the cycle after and completes correctly.
5. HRESETn pulsed low mid-RUN (async, between edges) -> outputs at reset values immediately. The next transaction is correct.
6. Round trip: random 1000 states through the forward SubBytes/ShiftRows model, then this block -> the original state is recovered. out_ready is randomly throttled; no drops or duplicates.
